// File: rtl/axi_sram_lat.sv
// AXI-Lite style SRAM slave with programmable read and write response latency.
// The read and write channels run independent FSMs over one shared word array.
module axi_sram_lat #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned WRITE_LAT = 1
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [31:0]         araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [31:0]         awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam int unsigned LSB         = $clog2(STRB_W);
    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam logic [32:0] SPAN        = 33'(DEPTH * STRB_W);
    localparam logic [32:0] LIMIT       = 33'(BASE_ADDR) + SPAN;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [3:0]  RD_CNT_INIT = 4'(READ_LAT - 1);
    localparam logic [3:0]  WR_CNT_INIT = 4'(WRITE_LAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] addr);
        return (33'(addr) >= 33'(BASE_ADDR)) && (33'(addr) < LIMIT);
    endfunction

    // Read path: address comes straight off the bus when sampling at the handshake.
    r_state_t          r_state;
    logic [3:0]        r_cnt;
    logic [31:0]       ar_addr_q;
    logic [31:0]       rd_addr_c;
    logic              rd_hit_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [DATA_W-1:0] rd_word_c;
    logic [1:0]        rd_resp_c;

    assign rd_addr_c = (r_state == R_IDLE) ? araddr : ar_addr_q;
    assign rd_hit_c  = in_range(rd_addr_c);
    assign rd_idx_c  = rd_addr_c[LSB +: IDX_W];
    assign rd_word_c = rd_hit_c ? mem[rd_idx_c] : '0;
    assign rd_resp_c = rd_hit_c ? RESP_OKAY : RESP_SLVERR;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        ar_addr_q <= araddr;
                        arready   <= 1'b0;
                        if (READ_LAT == 1) begin
                            r_state <= R_RESP;
                            rvalid  <= 1'b1;
                            rdata   <= rd_word_c;
                            rresp   <= rd_resp_c;
                        end else begin
                            r_state <= R_WAIT;
                            r_cnt   <= RD_CNT_INIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= R_RESP;
                        r_cnt   <= '0;
                        rvalid  <= 1'b1;
                        rdata   <= rd_word_c;
                        rresp   <= rd_resp_c;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state <= R_IDLE;
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write path: AW and W are captured independently; commit once both are present.
    w_state_t          w_state;
    logic [3:0]        w_cnt;
    logic              aw_held;
    logic              w_held;
    logic [31:0]       aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              aw_take_c;
    logic              w_take_c;
    logic              commit_c;
    logic [31:0]       wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [STRB_W-1:0] wr_strb_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic              wr_hit_c;

    assign aw_take_c = awvalid && awready;
    assign w_take_c  = wvalid && wready;
    assign commit_c  = (w_state == W_IDLE) && (aw_held || aw_take_c) && (w_held || w_take_c);
    assign wr_addr_c = aw_held ? aw_addr_q : awaddr;
    assign wr_data_c = w_held ? w_data_q : wdata;
    assign wr_strb_c = w_held ? w_strb_q : wstrb;
    assign wr_idx_c  = wr_addr_c[LSB +: IDX_W];
    assign wr_hit_c  = in_range(wr_addr_c);

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (commit_c) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        bresp   <= wr_hit_c ? RESP_OKAY : RESP_SLVERR;
                        if (WRITE_LAT == 1) begin
                            w_state <= W_RESP;
                            bvalid  <= 1'b1;
                        end else begin
                            w_state <= W_WAIT;
                            w_cnt   <= WR_CNT_INIT;
                        end
                    end else begin
                        if (aw_take_c) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= awaddr;
                        end
                        if (w_take_c) begin
                            w_held   <= 1'b1;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                        end
                        awready <= !(aw_held || aw_take_c);
                        wready  <= !(w_held || w_take_c);
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 4'd1) begin
                        w_state <= W_RESP;
                        w_cnt   <= '0;
                        bvalid  <= 1'b1;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Array update; a read sampling the same edge sees the pre-write contents.
    always_ff @(posedge aclk) begin
        if (!areset && commit_c && wr_hit_c) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wr_strb_c[i]) begin
                    mem[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
                end
            end
        end
    end

endmodule
